// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: owns the PC, drives a combinational
//               IMEM, captures into IF/ID, handles redirect/stall/flush and
//               traps misaligned redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                       PC_WIDTH_LENGTH   = 32,
  parameter int                       INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC      = 32'h00000000,
  parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST      = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_WIDTH_LENGTH-1:0]   PC,
  input  logic [INST_WIDTH_LENGTH-1:0] inst_in,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         br_taken,
  input  logic [PC_WIDTH_LENGTH-1:0]   br_target,
  output logic                         if_id_valid,
  output logic [PC_WIDTH_LENGTH-1:0]   if_id_PC,
  output logic [PC_WIDTH_LENGTH-1:0]   if_id_PC4,
  output logic [INST_WIDTH_LENGTH-1:0] if_id_inst,
  output logic                         misaligned,
  output logic [PC_WIDTH_LENGTH-1:0]   misaligned_addr,
  output logic [31:0]                  fetch_count
);

  localparam logic [PC_WIDTH_LENGTH-1:0] c_PC_STEP = PC_WIDTH_LENGTH'(4);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [PC_WIDTH_LENGTH-1:0]     pc_q, pc_d;
  logic                           valid_q, valid_d;
  logic [PC_WIDTH_LENGTH-1:0]     id_pc_q, id_pc_d;
  logic [PC_WIDTH_LENGTH-1:0]     id_pc4_q, id_pc4_d;
  logic [INST_WIDTH_LENGTH-1:0]   id_inst_q, id_inst_d;
  logic                           mis_q, mis_d;
  logic [PC_WIDTH_LENGTH-1:0]     mis_addr_q, mis_addr_d;
  logic [31:0]                    count_q, count_d;
  logic [PC_WIDTH_LENGTH-1:0]     pc_plus4;
  logic                           target_aligned;

  // Natural truncation gives the required wrap from the top word to zero.
  assign pc_plus4       = pc_q + c_PC_STEP;
  assign target_aligned = (br_target[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_inst_d  = id_inst_q;
    mis_d      = mis_q;
    mis_addr_d = mis_addr_q;
    count_d    = count_q;

    case (state_q)
      S_RUN: begin
        if (br_taken) begin
          valid_d   = 1'b0;
          id_inst_d = NOP_INST;
          if (target_aligned) begin
            pc_d = br_target;
          end else begin
            mis_d      = 1'b1;
            mis_addr_d = br_target;
            state_d    = S_HALT;
          end
        end else if (flush) begin
          // The killed slot is dropped, so the PC moves on unless held.
          valid_d   = 1'b0;
          id_inst_d = NOP_INST;
          if (!stall) begin
            pc_d = pc_plus4;
          end
        end else if (!stall) begin
          pc_d      = pc_plus4;
          valid_d   = 1'b1;
          id_pc_d   = pc_q;
          id_pc4_d  = pc_plus4;
          id_inst_d = inst_in;
          count_d   = count_q + 32'd1;
        end
      end
      S_HALT: begin
        valid_d   = 1'b0;
        id_inst_d = NOP_INST;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_inst_q  <= NOP_INST;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
      count_q    <= count_d;
    end
  end

  assign PC              = pc_q;
  assign if_id_valid     = valid_q;
  assign if_id_PC        = id_pc_q;
  assign if_id_PC4       = id_pc4_q;
  assign if_id_inst      = id_inst_q;
  assign misaligned      = mis_q;
  assign misaligned_addr = mis_addr_q;
  assign fetch_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit; IMEM word n
//               holds 0x100 + n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] inst_in;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_id_valid;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_PC4;
  logic [31:0] if_id_inst;
  logic        misaligned;
  logic [31:0] misaligned_addr;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .PC_WIDTH_LENGTH   (32),
    .INST_WIDTH_LENGTH (32),
    .RESET_PC          (32'h00000000),
    .NOP_INST          (32'h00000013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .inst_in         (inst_in),
    .stall           (stall),
    .flush           (flush),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .if_id_valid     (if_id_valid),
    .if_id_PC        (if_id_PC),
    .if_id_PC4       (if_id_PC4),
    .if_id_inst      (if_id_inst),
    .misaligned      (misaligned),
    .misaligned_addr (misaligned_addr),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inst_in = 32'h00000100 + {2'b00, PC[31:2]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".PC"},      PC,              32'h0);
    check({tag, ".valid"},   {31'd0, if_id_valid}, 32'h0);
    check({tag, ".idPC"},    if_id_PC,        32'h0);
    check({tag, ".idPC4"},   if_id_PC4,       32'h0);
    check({tag, ".inst"},    if_id_inst,      32'h00000013);
    check({tag, ".mis"},     {31'd0, misaligned}, 32'h0);
    check({tag, ".misaddr"}, misaligned_addr, 32'h0);
    check({tag, ".count"},   fetch_count,     32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    step();
    step();
    check_reset_state("reset");

    // Sequential fetch: after edge k, PC = 4k and IF/ID holds word k-1.
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("run%0d.PC", k),    PC,         32'(4 * k));
      check($sformatf("run%0d.inst", k),  if_id_inst, 32'(32'h100 + k - 1));
      check($sformatf("run%0d.idPC", k),  if_id_PC,   32'(4 * (k - 1)));
      check($sformatf("run%0d.valid", k), {31'd0, if_id_valid}, 32'h1);
    end
    check("run.count", fetch_count, 32'd4);

    // Two-cycle stall at PC 16: everything holds.
    stall = 1'b1;
    step();
    step();
    check("stall.PC",    PC,          32'd16);
    check("stall.inst",  if_id_inst,  32'h00000103);
    check("stall.idPC",  if_id_PC,    32'd12);
    check("stall.count", fetch_count, 32'd4);
    stall = 1'b0;
    step();
    check("resume.inst",  if_id_inst,  32'h00000104);
    check("resume.idPC",  if_id_PC,    32'd16);
    check("resume.PC",    PC,          32'd20);
    check("resume.count", fetch_count, 32'd5);

    // Flush alone: PC advances, slot becomes a bubble, IF/ID PC holds.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush.PC",    PC,          32'd24);
    check("flush.valid", {31'd0, if_id_valid}, 32'h0);
    check("flush.inst",  if_id_inst,  32'h00000013);
    check("flush.idPC",  if_id_PC,    32'd16);
    check("flush.count", fetch_count, 32'd5);

    // Branch overrides stall.
    br_taken = 1'b1; br_target = 32'h40; stall = 1'b1;
    step();
    br_taken = 1'b0; stall = 1'b0;
    check("br.PC",    PC,         32'h40);
    check("br.valid", {31'd0, if_id_valid}, 32'h0);
    check("br.inst",  if_id_inst, 32'h00000013);
    step();
    check("brtgt.inst",  if_id_inst,  32'h00000110);
    check("brtgt.idPC",  if_id_PC,    32'h40);
    check("brtgt.idPC4", if_id_PC4,   32'h44);
    check("brtgt.PC",    PC,          32'h44);
    check("brtgt.count", fetch_count, 32'd6);

    // Wrap from the top word.
    br_taken = 1'b1; br_target = 32'hFFFFFFFC;
    step();
    br_taken = 1'b0;
    check("wrapbr.PC", PC, 32'hFFFFFFFC);
    step();
    check("wrap.PC",    PC,         32'h00000000);
    check("wrap.idPC",  if_id_PC,   32'hFFFFFFFC);
    check("wrap.idPC4", if_id_PC4,  32'h00000000);
    check("wrap.inst",  if_id_inst, 32'h400000FF);
    check("wrap.count", fetch_count, 32'd7);

    // Misaligned redirect traps and halts.
    br_taken = 1'b1; br_target = 32'h42;
    step();
    check("mis.PC",    PC,              32'h0);
    check("mis.flag",  {31'd0, misaligned}, 32'h1);
    check("mis.addr",  misaligned_addr, 32'h42);
    check("mis.valid", {31'd0, if_id_valid}, 32'h0);
    br_taken = 1'b1; br_target = 32'h80; flush = 1'b1; stall = 1'b1;
    step();
    check("halt.PC",    PC,              32'h0);
    check("halt.flag",  {31'd0, misaligned}, 32'h1);
    check("halt.addr",  misaligned_addr, 32'h42);
    check("halt.inst",  if_id_inst,      32'h00000013);
    br_taken = 1'b0; flush = 1'b0; stall = 1'b0;
    step();
    step();
    check("halt2.PC",    PC,          32'h0);
    check("halt2.valid", {31'd0, if_id_valid}, 32'h0);
    check("halt2.count", fetch_count, 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("haltrst");

    // Reset mid-run together with a branch.
    step();
    step();
    check("mid.PC",    PC,          32'd8);
    check("mid.count", fetch_count, 32'd2);
    rst = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    step();
    rst = 1'b0; br_taken = 1'b0;
    check_reset_state("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and drives PC to the combinational IMEM. Captures the returned instruction into the IF/ID pipeline register for the decoder. Handles branch/jump redirects, pipeline stalls and flushes, misaligned-target trapping, and a retired-fetch counter.

Parameters:
PC_WIDTH_LENGTH, 32, width of PC and all address ports
INST_WIDTH_LENGTH, 32, instruction width
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/reset

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
PC  output  PC_WIDTH_LENGTH  current fetch address to IMEM
inst_in  input  INST_WIDTH_LENGTH  IMEM read data for PC, valid in the same cycle
stall  input  1  hazard-unit hold request
flush  input  1  kill the instruction being fetched this cycle
br_taken  input  1  redirect request from EX
br_target  input  PC_WIDTH_LENGTH  redirect address
if_id_valid  output  1  IF/ID register holds a real instruction
if_id_PC  output  PC_WIDTH_LENGTH  PC of the captured instruction
if_id_PC4  output  PC_WIDTH_LENGTH  captured PC + 4
if_id_inst  output  INST_WIDTH_LENGTH  captured instruction
misaligned  output  1  sticky: redirect to a non-word-aligned target
misaligned_addr  output  PC_WIDTH_LENGTH  offending target
fetch_count  output  32  count of instructions captured with valid = 1

Behaviour:
- Reset values: PC = RESET_PC, if_id_valid = 0, if_id_PC = 0, if_id_PC4 = 0, if_id_inst = NOP_INST, misaligned = 0, misaligned_addr = 0, fetch_count = 0. Reset overrides all other inputs and may occur mid-operation.
- IMEM is combinational. inst_in for PC is sampled at the same rising edge that advances PC. Result: one-cycle latency from PC to if_id_inst.
- Two states, RUN and HALT. Reset enters RUN.
- RUN, next-PC priority (highest first):
  - br_taken with br_target[1:0] == 0: PC <= br_target.
  - br_taken with br_target[1:0] != 0: PC holds; misaligned <= 1; misaligned_addr <= br_target; go to HALT.
  - stall: PC holds.
  - otherwise: PC <= PC + 4, modulo 2^PC_WIDTH_LENGTH (0xFFFFFFFC wraps to 0x00000000).
- RUN, IF/ID update (highest first):
  - br_taken or flush: valid <= 0, inst <= NOP_INST, if_id_PC and if_id_PC4 hold. A branch or flush overrides stall.
  - stall: all IF/ID fields hold.
  - otherwise: valid <= 1, if_id_PC <= PC, if_id_PC4 <= PC + 4, if_id_inst <= inst_in, fetch_count <= fetch_count + 1 (wraps at 2^32).
- flush without br_taken: PC still advances unless stall is asserted (the fetched slot is discarded, not refetched).
- HALT:
  - PC frozen.
  - IF/ID inserts a bubble every cycle: valid = 0, inst = NOP_INST.
  - stall, flush and br_taken are ignored.
  - misaligned stays 1 and misaligned_addr holds.
  - Only rst leaves HALT.
- PC[1:0] is always 2'b00 in RUN, so IMEM never returns high-Z into IF/ID.

Test Plan:
- Reset then run 4 cycles, IMEM word n = 0x100+n -> PC sequence 0, 4, 8, 12, 16; if_id_inst 0x100..0x103 with valid = 1; fetch_count = 4.
- stall high for 2 cycles at PC = 8 -> PC stays 8; IF/ID holds inst at PC 4; fetch_count unchanged; fetch resumes at 8 with no instruction lost.
- br_taken with br_target = 0x40 while stall = 1 -> next PC = 0x40; if_id_valid = 0 with if_id_inst = 0x00000013; next cycle captures the instruction at 0x40.
- br_taken with br_target = 0x42 -> misaligned = 1, misaligned_addr = 0x42, PC frozen, bubbles persist despite further br_taken; rst clears to PC = 0, misaligned = 0.
- PC preloaded via branch to 0xFFFFFFFC, no stall -> next PC = 0x00000000; if_id_PC4 = 0x00000000.
- rst asserted mid-run together with br_taken -> all outputs equal their reset values on the next edge.
